// File: rtl/elevator_request_scheduler_pkg.sv
// Shared constants, FSM encoding and one-hot helpers for the elevator request scheduler.
package elevator_pkg;

  localparam int unsigned FLOORS = 8;
  localparam int unsigned IDX_W  = $clog2(FLOORS);
  localparam logic [FLOORS-1:0] FLOOR_ONE = {{(FLOORS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    DWELL     = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [FLOORS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic onehot_valid(input logic [FLOORS-1:0] v);
    return (v != '0) && ((v & (v - FLOOR_ONE)) == '0);
  endfunction

endpackage

// File: rtl/elevator_request_scheduler_floor_picker.sv
// Combinational SCAN target selection: nearest pending floor in the sweep direction,
// reversing the sweep when nothing lies ahead.
module elevator_floor_picker
  import elevator_pkg::*;
(
  input  logic [FLOORS-1:0] pending,
  input  logic [IDX_W-1:0]  cur_idx,
  input  logic              sweep_up,
  output logic [FLOORS-1:0] target,
  output logic              found,
  output logic              next_sweep_up
);

  logic [FLOORS-1:0] ge_mask_s;
  logic [FLOORS-1:0] le_mask_s;
  logic [FLOORS-1:0] ge_s;
  logic [FLOORS-1:0] lt_s;
  logic [FLOORS-1:0] le_s;
  logic [FLOORS-1:0] gt_s;
  logic [IDX_W-1:0]  pick_idx_s;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [FLOORS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (m[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] highest_idx(input logic [FLOORS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (m[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Bit c sits in both the ">= c" and "<= c" halves so the current floor is always eligible.
  assign ge_mask_s = {FLOORS{1'b1}} << cur_idx;
  assign le_mask_s = ~(ge_mask_s << 1'd1);
  assign ge_s      = pending & ge_mask_s;
  assign lt_s      = pending & ~ge_mask_s;
  assign le_s      = pending & le_mask_s;
  assign gt_s      = pending & ~le_mask_s;

  // Pick the next target and the sweep direction that goes with it.
  always_comb begin
    found         = 1'b0;
    next_sweep_up = sweep_up;
    pick_idx_s    = '0;
    if (sweep_up) begin
      if (ge_s != '0) begin
        found         = 1'b1;
        pick_idx_s    = lowest_idx(ge_s);
        next_sweep_up = 1'b1;
      end else if (lt_s != '0) begin
        found         = 1'b1;
        pick_idx_s    = highest_idx(lt_s);
        next_sweep_up = 1'b0;
      end else begin
        found         = 1'b0;
        next_sweep_up = sweep_up;
      end
    end else begin
      if (le_s != '0) begin
        found         = 1'b1;
        pick_idx_s    = highest_idx(le_s);
        next_sweep_up = 1'b0;
      end else if (gt_s != '0) begin
        found         = 1'b1;
        pick_idx_s    = lowest_idx(gt_s);
        next_sweep_up = 1'b1;
      end else begin
        found         = 1'b0;
        next_sweep_up = sweep_up;
      end
    end
    if (found) begin
      target = FLOOR_ONE << pick_idx_s;
    end else begin
      target = '0;
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Latches floor calls, issues SCAN-ordered one-hot targets to the car controller,
// holds each until complete, dwells for door time and flags a stalled controller.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] call_buttons,
  input  logic [FLOORS-1:0] current_floor,
  input  logic              complete,
  output logic [FLOORS-1:0] request_floor,
  output logic              request_valid,
  output logic [FLOORS-1:0] pending,
  output logic              sweep_up,
  output logic              stall_alert
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned DW_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_CYCLES - 1);

  state_e            state_q, state_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [FLOORS-1:0] request_floor_q, request_floor_d;
  logic              request_valid_q, request_valid_d;
  logic              sweep_up_q, sweep_up_d;
  logic              stall_alert_q, stall_alert_d;
  logic [TO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;

  logic              cur_valid_s;
  logic [IDX_W-1:0]  cur_idx_s;
  logic [FLOORS-1:0] pick_target_s;
  logic              pick_found_s;
  logic              pick_next_up_s;
  logic [FLOORS-1:0] clear_mask_s;

  assign cur_valid_s = onehot_valid(current_floor);
  assign cur_idx_s   = onehot_to_idx(current_floor);

  elevator_floor_picker u_picker (
    .pending       (pending_q),
    .cur_idx       (cur_idx_s),
    .sweep_up      (sweep_up_q),
    .target        (pick_target_s),
    .found         (pick_found_s),
    .next_sweep_up (pick_next_up_s)
  );

  // Next-state and next-output logic for the issue / wait / dwell cycle.
  always_comb begin
    state_d         = state_q;
    request_floor_d = request_floor_q;
    request_valid_d = request_valid_q;
    sweep_up_d      = sweep_up_q;
    stall_alert_d   = stall_alert_q;
    tmo_cnt_d       = tmo_cnt_q;
    dwell_cnt_d     = dwell_cnt_q;
    clear_mask_s    = '0;
    case (state_q)
      IDLE: begin
        // found already implies pending is non-zero
        if (cur_valid_s && pick_found_s) begin
          request_floor_d = pick_target_s;
          request_valid_d = 1'b1;
          sweep_up_d      = pick_next_up_s;
          tmo_cnt_d       = '0;
          state_d         = WAIT_DONE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (complete) begin
          clear_mask_s    = request_floor_q;
          request_floor_d = '0;
          request_valid_d = 1'b0;
          stall_alert_d   = 1'b0;
          tmo_cnt_d       = '0;
          dwell_cnt_d     = '0;
          state_d         = DWELL;
        end else begin
          if (tmo_cnt_q != TO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TO_W'(1);
          end else begin
            tmo_cnt_d = tmo_cnt_q;
          end
          if (tmo_cnt_d == TO_MAX) begin
            stall_alert_d = 1'b1;
          end else begin
            stall_alert_d = stall_alert_q;
          end
        end
      end
      DWELL: begin
        if (dwell_cnt_q == DW_MAX) begin
          dwell_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          dwell_cnt_d = dwell_cnt_q + DW_W'(1);
        end
      end
      default: begin
        request_floor_d = '0;
        request_valid_d = 1'b0;
        stall_alert_d   = 1'b0;
        tmo_cnt_d       = '0;
        dwell_cnt_d     = '0;
        state_d         = IDLE;
      end
    endcase
    // A press on the floor being cleared this cycle is absorbed by the clear.
    pending_d = (pending_q | call_buttons) & ~clear_mask_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      pending_q       <= '0;
      request_floor_q <= '0;
      request_valid_q <= 1'b0;
      sweep_up_q      <= 1'b1;
      stall_alert_q   <= 1'b0;
      tmo_cnt_q       <= '0;
      dwell_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      request_floor_q <= request_floor_d;
      request_valid_q <= request_valid_d;
      sweep_up_q      <= sweep_up_d;
      stall_alert_q   <= stall_alert_d;
      tmo_cnt_q       <= tmo_cnt_d;
      dwell_cnt_q     <= dwell_cnt_d;
    end
  end

  assign request_floor = request_floor_q;
  assign request_valid = request_valid_q;
  assign pending       = pending_q;
  assign sweep_up      = sweep_up_q;
  assign stall_alert   = stall_alert_q;

endmodule
